dff_checker: RTL and testbench

- Synthesizable in-circuit monitor for a registered data path (D flip-flop or N-stage register chain). It is the checking end of the D/Q interface.
- Samples the DUT's d, q, qb and DUT reset on every clock edge. Checks the reset value, the D-to-Q transfer after LATENCY cycles, and Q/QB complementarity.
- Counts and classifies violations and captures the first failure. Sits beside the DUT in silicon-debug and FPGA builds, where simulation assertions are unavailable.

---
 rtl/dff_check_pkg.sv | 17 +
 rtl/dff_check_dly.sv | 47 ++++
 rtl/dff_checker.sv | 145 ++++++++++++++
 tb/tb_dff_checker.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_check_pkg.sv
// Shared types and constants for the D/Q interface checker.
package dff_check_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RSTCHK = 3'd1,
        ARMING = 3'd2,
        CHECK  = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam int ERR_RST     = 0;
    localparam int ERR_XFER    = 1;
    localparam int ERR_COMP    = 2;
    localparam int LATENCY_MAX = 8;

endpackage

// File: rtl/dff_check_dly.sv
// Delay line holding the last DEPTH sampled d values, with a valid bit per stage.
module dff_check_dly #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             vld_last,
    output logic             vld_pre
);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) data[i] <= '0;
        end else if (flush) begin
            vld <= '0;
        end else if (shift) begin
            data[0] <= din;
            vld[0]  <= 1'b1;
            for (int i = 1; i < DEPTH; i++) begin
                data[i] <= data[i-1];
                vld[i]  <= vld[i-1];
            end
        end
    end

    assign dout     = data[DEPTH-1];
    assign vld_last = vld[DEPTH-1];

    // vld_pre: the last stage becomes valid on the next shift
    generate
        if (DEPTH == 1) begin : g_pre_one
            assign vld_pre = 1'b1;
        end else begin : g_pre_many
            assign vld_pre = vld[DEPTH-2];
        end
    endgenerate

endmodule

// File: rtl/dff_checker.sv
// In-circuit monitor for a registered D/Q path: reset value, D-to-Q transfer
// after LATENCY cycles and Q/QB complementarity, with counters and first-error capture.
//   state  | meaning
//   IDLE   | checking disabled, delay line flushed
//   RSTCHK | DUT held in reset, q/qb must show reset values
//   ARMING | filling the delay line, complement check only
//   CHECK  | transfer and complement checks, cycle counting
//   HALT   | frozen after first error, left only by clr/rst
module dff_checker
    import dff_check_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int LATENCY     = 1,
    parameter int CNT_W       = 16,
    parameter int HALT_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             dut_rst_n,
    input  logic [WIDTH-1:0] dut_d,
    input  logic [WIDTH-1:0] dut_q,
    input  logic [WIDTH-1:0] dut_qb,
    output logic             err,
    output logic [2:0]       err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] first_cyc,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_act,
    output logic             halted
);

    localparam int DEPTH   = (LATENCY < 1) ? 1 :
                             ((LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY);
    localparam bit HALT_EN = (HALT_ON_ERR != 0);

    state_t           state, state_nxt;
    logic [2:0]       err_vec;
    logic             any_err;
    logic             comp_bad;
    logic [WIDTH-1:0] dly_q;
    logic             dly_vld, dly_vld_pre;
    logic             dly_shift, dly_flush;

    dff_check_dly #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dly (
        .clk      (clk),
        .rst      (rst),
        .flush    (dly_flush | clr),
        .shift    (dly_shift),
        .din      (dut_d),
        .dout     (dly_q),
        .vld_last (dly_vld),
        .vld_pre  (dly_vld_pre)
    );

    assign comp_bad = (dut_qb != ~dut_q);
    assign any_err  = |err_vec;
    assign halted   = (state == HALT);

    always_comb begin
        state_nxt = state;
        err_vec   = '0;
        dly_shift = 1'b0;
        dly_flush = 1'b1;
        if (state != HALT && !en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = dut_rst_n ? ARMING : RSTCHK;
                RSTCHK: begin
                    err_vec[ERR_RST] = (dut_q != '0) || (dut_qb != '1);
                    if (err_vec[ERR_RST] && HALT_EN) state_nxt = HALT;
                    else if (dut_rst_n)              state_nxt = ARMING;
                end
                ARMING: begin
                    err_vec[ERR_COMP] = comp_bad;
                    if (!dut_rst_n) begin
                        state_nxt = RSTCHK;
                    end else begin
                        dly_flush = 1'b0;
                        dly_shift = 1'b1;
                        if (dly_vld_pre) state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    // no transfer check while the DUT is being reset
                    err_vec[ERR_COMP] = comp_bad;
                    err_vec[ERR_XFER] = dut_rst_n && dly_vld && (dut_q != dly_q);
                    if ((err_vec[ERR_COMP] || err_vec[ERR_XFER]) && HALT_EN) begin
                        state_nxt = HALT;
                    end else if (!dut_rst_n) begin
                        state_nxt = RSTCHK;
                    end else begin
                        dly_flush = 1'b0;
                        dly_shift = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            err        <= 1'b0;
            err_sticky <= '0;
            err_cnt    <= '0;
            cyc_cnt    <= '0;
            first_cyc  <= '0;
            first_exp  <= '0;
            first_act  <= '0;
        end else if (clr) begin
            state      <= IDLE;
            err        <= 1'b0;
            err_sticky <= '0;
            err_cnt    <= '0;
            cyc_cnt    <= '0;
            first_cyc  <= '0;
            first_exp  <= '0;
            first_act  <= '0;
        end else begin
            state <= state_nxt;
            err   <= any_err;
            if (state == CHECK && en && cyc_cnt != '1) cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (any_err) begin
                err_sticky <= err_sticky | err_vec;
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                if (err_cnt == '0) begin
                    first_cyc <= cyc_cnt;
                    if (err_vec[ERR_XFER]) begin
                        first_exp <= dly_q;
                        first_act <= dut_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dff_checker.sv
// Bench for dff_checker: three checker variants watch behavioural register chains
// with injected faults; outputs compared against a spec-level reference model.
module tb_dff_checker;

    localparam int NI = 3;
    localparam int M_IDLE = 0, M_RST = 1, M_ARM = 2, M_CHK = 3, M_HALT = 4;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int cw_of(input int g);
        return (g == 0) ? 4 : 16;
    endfunction

    function automatic int hlt_of(input int g);
        return (g == 2) ? 1 : 0;
    endfunction

    logic       clk, rst, en, clr, dut_rst_n;
    logic [3:0] dut_d;
    logic [3:0] q_xor [NI];
    logic [3:0] qb_xor [NI];

    logic [3:0]  q_w [NI];
    logic [3:0]  qb_w [NI];
    logic        err_w [NI];
    logic [2:0]  stk_w [NI];
    logic [15:0] ecnt_w [NI];
    logic [15:0] ccnt_w [NI];
    logic [15:0] fcyc_w [NI];
    logic [3:0]  fexp_w [NI];
    logic [3:0]  fact_w [NI];
    logic        halt_w [NI];

    int n_chk = 0;
    int n_err = 0;
    int rn_low = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = lat_of(g);
        localparam int C = cw_of(g);

        logic [3:0]   chain [L];
        logic         e_o, h_o;
        logic [2:0]   s_o;
        logic [C-1:0] ec_o, cc_o, fc_o;
        logic [3:0]   fx_o, fa_o;

        // the monitored DUT: L-stage register chain with async active-low reset
        always_ff @(posedge clk or negedge dut_rst_n) begin
            if (!dut_rst_n) begin
                for (int k = 0; k < L; k++) chain[k] <= '0;
            end else begin
                chain[0] <= dut_d;
                for (int k = 1; k < L; k++) chain[k] <= chain[k-1];
            end
        end

        assign q_w[g]  = chain[L-1] ^ q_xor[g];
        assign qb_w[g] = ~q_w[g] ^ qb_xor[g];

        dff_checker #(
            .WIDTH       (4),
            .LATENCY     (L),
            .CNT_W       (C),
            .HALT_ON_ERR (hlt_of(g))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .clr        (clr),
            .dut_rst_n  (dut_rst_n),
            .dut_d      (dut_d),
            .dut_q      (q_w[g]),
            .dut_qb     (qb_w[g]),
            .err        (e_o),
            .err_sticky (s_o),
            .err_cnt    (ec_o),
            .cyc_cnt    (cc_o),
            .first_cyc  (fc_o),
            .first_exp  (fx_o),
            .first_act  (fa_o),
            .halted     (h_o)
        );

        assign err_w[g]  = e_o;
        assign stk_w[g]  = s_o;
        assign ecnt_w[g] = 16'(ec_o);
        assign ccnt_w[g] = 16'(cc_o);
        assign fcyc_w[g] = 16'(fc_o);
        assign fexp_w[g] = fx_o;
        assign fact_w[g] = fa_o;
        assign halt_w[g] = h_o;
    end

    // reference model state, one slot per checker variant
    int         m_mode [NI];
    int         m_n [NI];
    logic [3:0] m_hist [NI][8];
    bit         e_err [NI];
    logic [2:0] e_stk [NI];
    int         e_ec [NI];
    int         e_cc [NI];
    int         e_fc [NI];
    logic [3:0] e_fx [NI];
    logic [3:0] e_fa [NI];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_mode[i] = M_IDLE;
        m_n[i]    = 0;
        e_err[i]  = 1'b0;
        e_stk[i]  = '0;
        e_ec[i]   = 0;
        e_cc[i]   = 0;
        e_fc[i]   = 0;
        e_fx[i]   = '0;
        e_fa[i]   = '0;
    endtask

    task automatic push_d(input int i, input logic [3:0] d);
        for (int k = 7; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = d;
        if (m_n[i] < 8) m_n[i]++;
    endtask

    task automatic model_step(input int i);
        bit x, c, r;
        int lat, cmax, cc_old;
        logic [3:0] q, qb, exp_q;
        lat    = lat_of(i);
        cmax   = (1 << cw_of(i)) - 1;
        q      = q_w[i];
        qb     = qb_w[i];
        exp_q  = m_hist[i][lat-1];
        cc_old = e_cc[i];
        x = 0; c = 0; r = 0;
        if (clr) begin
            model_reset(i);
            return;
        end
        e_err[i] = 1'b0;
        if (m_mode[i] == M_HALT) return;
        if (!en) begin
            m_mode[i] = M_IDLE;
            m_n[i]    = 0;
            return;
        end
        case (m_mode[i])
            M_IDLE: begin
                m_mode[i] = dut_rst_n ? M_ARM : M_RST;
                m_n[i]    = 0;
            end
            M_RST: begin
                r = (q != 4'h0) || (qb != 4'hF);
                if (r && hlt_of(i) != 0) m_mode[i] = M_HALT;
                else if (dut_rst_n)      m_mode[i] = M_ARM;
            end
            M_ARM: begin
                c = (qb != ~q);
                if (!dut_rst_n) begin
                    m_mode[i] = M_RST;
                    m_n[i]    = 0;
                end else begin
                    push_d(i, dut_d);
                    if (m_n[i] >= lat) m_mode[i] = M_CHK;
                end
            end
            M_CHK: begin
                if (e_cc[i] < cmax) e_cc[i]++;
                c = (qb != ~q);
                x = dut_rst_n && (m_n[i] >= lat) && (q != exp_q);
                if ((x || c) && hlt_of(i) != 0) m_mode[i] = M_HALT;
                else if (!dut_rst_n) begin
                    m_mode[i] = M_RST;
                    m_n[i]    = 0;
                end else push_d(i, dut_d);
            end
            default: ;
        endcase
        if (x || c || r) begin
            e_err[i] = 1'b1;
            if (e_ec[i] == 0) begin
                e_fc[i] = cc_old;
                if (x) begin
                    e_fx[i] = exp_q;
                    e_fa[i] = q;
                end
            end
            if (e_ec[i] < cmax) e_ec[i]++;
            e_stk[i] = e_stk[i] | {c, x, r};
        end
    endtask

    task automatic check_inst(input int i);
        check($sformatf("u%0d.err", i),        32'(err_w[i]),  32'(e_err[i]));
        check($sformatf("u%0d.err_sticky", i), 32'(stk_w[i]),  32'(e_stk[i]));
        check($sformatf("u%0d.err_cnt", i),    32'(ecnt_w[i]), 32'(e_ec[i]));
        check($sformatf("u%0d.cyc_cnt", i),    32'(ccnt_w[i]), 32'(e_cc[i]));
        check($sformatf("u%0d.first_cyc", i),  32'(fcyc_w[i]), 32'(e_fc[i]));
        check($sformatf("u%0d.first_exp", i),  32'(fexp_w[i]), 32'(e_fx[i]));
        check($sformatf("u%0d.first_act", i),  32'(fact_w[i]), 32'(e_fa[i]));
        check($sformatf("u%0d.halted", i),     32'(halt_w[i]), 32'(m_mode[i] == M_HALT));
    endtask

    task automatic tick();
        #1;
        for (int i = 0; i < NI; i++) model_step(i);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_inst(i);
    endtask

    task automatic apply_rst();
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) model_reset(i);
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_inst(i);
        rst = 1'b0;
    endtask

    task automatic set_xor(input logic [3:0] qx, input logic [3:0] qbx);
        for (int i = 0; i < NI; i++) begin
            q_xor[i]  = qx;
            qb_xor[i] = qbx;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; dut_rst_n = 1'b0; dut_d = '0;
        set_xor(4'h0, 4'h0);
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 8; k++) m_hist[i][k] = '0;
        apply_rst();

        // DUT held in reset while checking is enabled
        en = 1'b1;
        repeat (3) tick();

        // release and run a clean data stream
        dut_rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            dut_d = 4'($urandom);
            tick();
        end

        // single-cycle transfer fault, then a complement fault
        dut_d = 4'($urandom); set_xor(4'h1, 4'h0); tick();
        set_xor(4'h0, 4'h0);
        repeat (3) begin dut_d = 4'($urandom); tick(); end
        dut_d = 4'($urandom); set_xor(4'h0, 4'h4); tick();
        set_xor(4'h0, 4'h0);
        repeat (2) begin dut_d = 4'($urandom); tick(); end

        // further faults while the halting variant is frozen
        set_xor(4'h1, 4'h0);
        repeat (5) begin dut_d = 4'($urandom); tick(); end
        set_xor(4'h0, 4'h0);

        clr = 1'b1; tick(); clr = 1'b0;

        // DUT reset mid-run, then re-arm
        repeat (10) begin dut_d = 4'($urandom); tick(); end
        dut_rst_n = 1'b0;
        repeat (2) begin dut_d = 4'($urandom); tick(); end
        dut_rst_n = 1'b1;
        repeat (8) begin dut_d = 4'($urandom); tick(); end

        apply_rst();

        // randomized phase
        for (int cyc = 0; cyc < 700; cyc++) begin
            dut_d = 4'($urandom);
            if (rn_low > 0) begin
                dut_rst_n = 1'b0;
                rn_low--;
            end else if ($urandom_range(0, 29) == 0) begin
                dut_rst_n = 1'b0;
                rn_low = $urandom_range(0, 2);
            end else begin
                dut_rst_n = 1'b1;
            end
            en  = ($urandom_range(0, 39) != 0);
            clr = ($urandom_range(0, 119) == 0);
            for (int i = 0; i < NI; i++) begin
                q_xor[i]  = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                qb_xor[i] = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            tick();
        end
        clr = 1'b0;
        set_xor(4'h0, 4'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
